// File: rtl/mutex_pkg.sv
// Shared types and field layout for the hardware mutex lock master.
// The mutex register packs an owner id in the upper half and a lock value in the lower half.
package mutex_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_CLAIM,
      RD_CHECK,
      BACKOFF,
      HELD,
      WR_RELEASE
   } state_t;

   localparam logic [31:0] MUTEX_REG_OFS = 32'd0;
   localparam logic [31:0] RESET_REG_OFS = 32'd4;

   localparam int OWNER_MSB = 31;
   localparam int OWNER_LSB = 16;
   localparam int VALUE_MSB = 15;
   localparam int VALUE_LSB = 0;

   function automatic logic [31:0] pack_mutex(input logic [15:0] owner, input logic [15:0] value);
      logic [31:0] word;
      word = '0;
      word[OWNER_MSB:OWNER_LSB] = owner;
      word[VALUE_MSB:VALUE_LSB] = value;
      return word;
   endfunction

endpackage

// File: rtl/mutex_backoff_timer.sv
// Down-counter used to space out claim retries; loads a length and counts to zero.
module mutex_backoff_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (dec && (count_reg != '0)) begin
         count_reg <= count_reg - WIDTH'(1);
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/mutex_lock_master.sv
// Avalon-MM master that claims, confirms and releases one hardware mutex for local logic.
// All outputs are registered and decoded from the next state, so nothing is combinational from inputs.
module mutex_lock_master
   import mutex_pkg::*;
#(
   parameter logic [31:0] MUTEX_BASE     = 32'h0000_0000,
   parameter logic [15:0] OWNER_ID       = 16'h0001,
   parameter logic [15:0] LOCK_VALUE     = 16'h0001,
   parameter int          BACKOFF_CYCLES = 8,
   parameter int          MAX_RETRIES    = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        lock_req,
   input  logic        unlock_req,
   output logic        lock_granted,
   output logic        lock_fail,
   output logic        busy,
   output logic [7:0]  attempt_count,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest
);

   localparam int          TIMER_W      = (BACKOFF_CYCLES < 2) ? 1 : $clog2(BACKOFF_CYCLES + 1);
   localparam logic [31:0] CLAIM_WORD   = pack_mutex(OWNER_ID, LOCK_VALUE);
   localparam logic [31:0] RELEASE_WORD = pack_mutex(OWNER_ID, 16'h0000);

   state_t     state_reg;
   state_t     state_next;
   logic [7:0] attempt_next;
   logic       fail_next;
   logic       timer_load;
   logic       timer_dec;
   logic       timer_zero;

   assign avm_address = MUTEX_BASE + MUTEX_REG_OFS;

   mutex_backoff_timer #(
      .WIDTH (TIMER_W)
   ) u_backoff_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (timer_load),
      .load_value (TIMER_W'(BACKOFF_CYCLES)),
      .dec        (timer_dec),
      .zero       (timer_zero)
   );

   always_comb begin
      state_next   = state_reg;
      attempt_next = attempt_count;
      fail_next    = 1'b0;
      timer_load   = 1'b0;
      timer_dec    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (lock_req) begin
               state_next   = WR_CLAIM;
               attempt_next = 8'd0;
            end
         end
         WR_CLAIM: begin
            if (!avm_waitrequest) state_next = RD_CHECK;
         end
         RD_CHECK: begin
            if (!avm_waitrequest) begin
               if (avm_readdata == CLAIM_WORD) begin
                  state_next = HELD;
               end else begin
                  attempt_next = (attempt_count == 8'hFF) ? 8'hFF : attempt_count + 8'd1;
                  if ((MAX_RETRIES != 0) && (int'(attempt_next) == MAX_RETRIES)) begin
                     state_next = IDLE;
                     fail_next  = 1'b1;
                  end else begin
                     state_next = BACKOFF;
                     timer_load = 1'b1;
                  end
               end
            end
         end
         BACKOFF: begin
            // A withdrawn request cancels before the next claim goes out.
            if (!lock_req) begin
               state_next = IDLE;
            end else if (timer_zero) begin
               state_next = WR_CLAIM;
            end else begin
               timer_dec = 1'b1;
            end
         end
         HELD: begin
            if (unlock_req) state_next = WR_RELEASE;
         end
         WR_RELEASE: begin
            if (!avm_waitrequest) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         attempt_count <= 8'd0;
         lock_fail     <= 1'b0;
         lock_granted  <= 1'b0;
         busy          <= 1'b0;
         avm_read      <= 1'b0;
         avm_write     <= 1'b0;
         avm_writedata <= 32'd0;
      end else begin
         state_reg     <= state_next;
         attempt_count <= attempt_next;
         lock_fail     <= fail_next;
         lock_granted  <= (state_next == HELD);
         busy          <= (state_next == WR_CLAIM) || (state_next == RD_CHECK) ||
                          (state_next == BACKOFF)  || (state_next == WR_RELEASE);
         avm_read      <= (state_next == RD_CHECK);
         avm_write     <= (state_next == WR_CLAIM) || (state_next == WR_RELEASE);
         if (state_next == WR_CLAIM) begin
            avm_writedata <= CLAIM_WORD;
         end else if (state_next == WR_RELEASE) begin
            avm_writedata <= RELEASE_WORD;
         end else begin
            avm_writedata <= 32'd0;
         end
      end
   end

endmodule
